// File: rtl/exe_div_ctrl.sv
// exe_div_ctrl: sequencing controller for the shared iterative divider used
// by the execute stage.
//
// state | meaning
// IDLE  | no divide in flight; issues a start when a DIV/DIVU sits in EXE
// ZERO  | divisor was zero; result forced to 0 without using the core
// BUSY  | core is working; wait for div_ready_i or the timeout
// DONE  | result held and valid until the instruction leaves EXE
//
// Ports:
//   cpu_clk_50M, cpu_rst         clock, synchronous active-high reset
//   exe_aluop_i, exe_src1_i/2_i  instruction and operands in EXE
//   flush_i, stall_down_i        pipeline kill / later-stage stall
//   stallreq_div                 stall request while a result is pending
//   div_start_o, div_signed_o,
//   div_op1_o, div_op2_o,
//   div_annul_o                  divider core command side
//   div_ready_i, div_result_i    divider core result side {rem, quot}
//   div_res_o, div_valid_o,
//   div_err_o                    held result {HI, LO}, valid, timeout flag
module exe_div_ctrl #(
  parameter int         DIV_TIMEOUT = 40,
  parameter logic [7:0] DIV_OP      = 8'h16,
  parameter logic [7:0] DIVU_OP     = 8'h17
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic [7:0]  exe_aluop_i,
  input  logic [31:0] exe_src1_i,
  input  logic [31:0] exe_src2_i,
  input  logic        flush_i,
  input  logic        stall_down_i,
  output logic        stallreq_div,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        div_annul_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic [63:0] div_res_o,
  output logic        div_valid_o,
  output logic        div_err_o
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(DIV_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   res_q, res_d;
  logic          err_q, err_d;
  logic          isdiv;
  logic          start;
  logic          annul;

  assign isdiv = (exe_aluop_i == DIV_OP) || (exe_aluop_i == DIVU_OP);

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    start   = 1'b0;
    annul   = 1'b0;
    if (flush_i) begin
      // A flush kills the EXE instruction whatever we were doing.
      state_d = IDLE;
      cnt_d   = '0;
      res_d   = '0;
      err_d   = 1'b0;
      annul   = (state_q == BUSY);
    end else begin
      case (state_q)
        IDLE: begin
          if (isdiv) begin
            err_d = 1'b0;
            if (exe_src2_i == 32'd0) begin
              state_d = ZERO;
            end else begin
              start   = 1'b1;
              // Counter reads 1 in the first BUSY cycle so it equals the
              // number of BUSY cycles spent so far.
              cnt_d   = CW'(1);
              state_d = BUSY;
            end
          end
        end
        ZERO: begin
          res_d   = '0;
          err_d   = 1'b0;
          state_d = DONE;
        end
        BUSY: begin
          cnt_d = cnt_q + CW'(1);
          if (div_ready_i) begin
            res_d   = div_result_i;
            err_d   = 1'b0;
            state_d = DONE;
          end else if (cnt_q == CNT_LIMIT) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          if (!stall_down_i) begin
            state_d = IDLE;
            err_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Core commands are suppressed during reset: the core shares cpu_rst.
  assign div_start_o  = start && !cpu_rst;
  assign div_annul_o  = annul && !cpu_rst;
  assign div_signed_o = div_start_o && (exe_aluop_i == DIV_OP);
  assign div_op1_o    = div_start_o ? exe_src1_i : 32'd0;
  assign div_op2_o    = div_start_o ? exe_src2_i : 32'd0;

  assign stallreq_div = isdiv && (state_q != DONE) && !flush_i && !cpu_rst;
  assign div_valid_o  = (state_q == DONE);
  assign div_err_o    = (state_q == DONE) && err_q;
  assign div_res_o    = res_q;

endmodule

// File: tb/tb_exe_div_ctrl.sv
module tb_exe_div_ctrl;

  localparam int         TO      = 40;
  localparam logic [7:0] OP_DIV  = 8'h16;
  localparam logic [7:0] OP_DIVU = 8'h17;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] src1, src2;
  logic        flush, stall_down;
  logic        stallreq, start, signed_op, annul;
  logic [31:0] op1, op2;
  logic        ready;
  logic [63:0] result;
  logic [63:0] res;
  logic        valid, err;

  exe_div_ctrl #(.DIV_TIMEOUT(TO)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .exe_aluop_i (aluop),
    .exe_src1_i  (src1),
    .exe_src2_i  (src2),
    .flush_i     (flush),
    .stall_down_i(stall_down),
    .stallreq_div(stallreq),
    .div_start_o (start),
    .div_signed_o(signed_op),
    .div_op1_o   (op1),
    .div_op2_o   (op2),
    .div_annul_o (annul),
    .div_ready_i (ready),
    .div_result_i(result),
    .div_res_o   (res),
    .div_valid_o (valid),
    .div_err_o   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, expv);
    end
  endtask

  // Divider core model: ready pulse m_lat cycles after the start cycle.
  int          m_lat = 1;
  logic        m_never = 1'b0;
  logic [63:0] m_res = '0;
  initial begin
    ready  = 1'b0;
    result = '0;
    forever begin
      @(negedge clk);
      if (start && !m_never) begin
        for (int i = 1; i < m_lat; i++) @(negedge clk);
        @(posedge clk); #1;
        ready  = 1'b1;
        result = m_res;
        @(posedge clk); #1;
        ready  = 1'b0;
        result = '0;
      end
    end
  end

  // Monitor: compare each new valid result against the scoreboard.
  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (start && annul) chk("start_with_annul", 1, 0);
    if (valid && !vprev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {res, err}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", res, e.res);
        chk("err", err, e.err);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
    vprev = valid;
  end

  task automatic do_div(input string name, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic never,
                        input logic [63:0] core_res, input logic [63:0] exp_res,
                        input logic exp_err, input int s);
    int t0, dly, nstall, nstart, budget;
    @(posedge clk); #1;
    m_lat = lat; m_never = never; m_res = core_res;
    aluop = op; src1 = a; src2 = b; stall_down = (s > 0);
    t0  = cyc;
    dly = (b == 0) ? 2 : (never ? TO + 1 : lat + 1);
    exp_q.push_back('{exp_res, exp_err, t0 + dly});
    @(negedge clk);
    if (b != 0)
      chk({name, "_issue"}, {start, signed_op, op1, op2}, {1'b1, op == OP_DIV, a, b});
    nstall = 0; nstart = 0; budget = 0;
    while (!valid && budget < 200) begin
      nstall += int'(stallreq);
      nstart += int'(start);
      budget++;
      @(negedge clk);
    end
    chk({name, "_valid_seen"}, valid, 1);
    chk({name, "_stall_cycles"}, nstall, dly);
    chk({name, "_starts"}, nstart, (b != 0) ? 1 : 0);
    chk({name, "_stall_in_done"}, stallreq, 0);
    for (int k = 0; k < s; k++) begin
      @(posedge clk); #1;
      if (k == s - 1) stall_down = 1'b0;
      @(negedge clk);
      chk({name, "_hold"}, {valid, start, stallreq, res}, {1'b1, 1'b0, 1'b0, exp_res});
    end
    @(posedge clk); #1;
    aluop = 8'h00; src1 = '0; src2 = '0;
    @(negedge clk);
    chk({name, "_idle_after"}, {valid, err}, 0);
  endtask

  initial begin
    int t0;
    rst = 1'b1; aluop = 8'h00; src1 = '0; src2 = '0; flush = 1'b0; stall_down = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {stallreq, start, signed_op, annul, valid, err, res, op1, op2}, 0);

    do_div("div_100_7", OP_DIV, 32'd100, 32'd7, 17, 1'b0,
           {32'd2, 32'd14}, 64'h00000002_0000000E, 1'b0, 0);
    do_div("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 5, 1'b0,
           {32'hFFFFFFFF, 32'hFFFFFFFD}, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 0);
    do_div("divu_max", OP_DIVU, 32'hFFFFFFFF, 32'd2, 3, 1'b0,
           {32'd1, 32'h7FFFFFFF}, {32'd1, 32'h7FFFFFFF}, 1'b0, 0);
    do_div("div_zero", OP_DIV, 32'd5, 32'd0, 1, 1'b0, '0, '0, 1'b0, 0);
    do_div("stall_down", OP_DIVU, 32'd50, 32'd5, 4, 1'b0,
           {32'd0, 32'd10}, {32'd0, 32'd10}, 1'b0, 3);

    // Flush mid-divide: annul once, then nothing comes back.
    @(posedge clk); #1;
    m_lat = 17; m_never = 1'b0; m_res = {32'd2, 32'd14};
    aluop = OP_DIV; src1 = 32'd100; src2 = 32'd7;
    t0 = cyc;
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle", {annul, start, stallreq}, {1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    flush = 1'b0; aluop = 8'h00; src1 = '0; src2 = '0;
    @(negedge clk);
    chk("after_flush", {annul, stallreq, valid}, 0);
    while (cyc < t0 + 20) @(negedge clk);
    chk("flush_no_valid", valid, 0);

    do_div("timeout", OP_DIV, 32'd9, 32'd3, 1, 1'b1, '0, '0, 1'b1, 0);

    // Reset mid-BUSY, after a result has been left in the register.
    do_div("pre_reset", OP_DIVU, 32'd8, 32'd3, 2, 1'b0,
           {32'd2, 32'd2}, {32'd2, 32'd2}, 1'b0, 0);
    @(posedge clk); #1;
    m_never = 1'b1;
    aluop = OP_DIV; src1 = 32'd9; src2 = 32'd3;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_no_annul", annul, 0);
    @(posedge clk); #1;
    rst = 1'b0; aluop = 8'h00; src1 = '0; src2 = '0;
    @(negedge clk);
    chk("reset_mid_busy", {stallreq, start, signed_op, annul, valid, err, res, op1, op2}, 0);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
